edge_line_unpacker: RTL and testbench
=====================================

EDGE_LINE_UNPACKER -- requirements
Module: edge_line_unpacker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, line buffer depth in 512-bit entries (power of two, >=8).
REQ-002 SHALL have parameter DROP_HI, default FIFO_DEPTH-2, occupancy at which drop asserts.
REQ-003 SHALL have parameter DROP_LO, default FIFO_DEPTH-4, occupancy at which drop deasserts.
REQ-004 SHALL have ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a transfer.
num_edges  in  32  edges to emit; sampled on start.
line_in  in  512  cache line from the read engine.
line_valid  in  1  line_in valid; no backpressure.
drop  out  1  asks the read engine to discard in-flight lines and re-request.
edge_src  out  32  edge source vertex.
edge_dst  out  32  edge destination vertex.
edge_weight  out  32  edge weight.
edge_valid  out  1  edge fields valid.
edge_ready  in  1  consumer accepts the edge.
edge_last  out  1  marks the final edge of the transfer.
done  out  1  one-cycle pulse at transfer end.
overflow_err  out  1  sticky; a line arrived while the FIFO was full.

Function
REQ-005 SHALL implement states IDLE, RUN, FINISH.
REQ-006 IDLE->RUN on start; IDLE->FINISH on start with num_edges==0.
REQ-007 RUN->FINISH in the cycle after the handshake of the edge with edge_last=1.
REQ-008 FINISH->IDLE unconditionally; done=1 only in FINISH.
REQ-009 start outside IDLE SHALL be ignored.
REQ-010 In RUN, every cycle with line_valid=1 SHALL write line_in to the FIFO; line_valid outside RUN SHALL be ignored.
REQ-011 Each line SHALL hold 4 edges, lane k = bits [128k+127:128k], emitted in order k=0..3.
REQ-012 Within a lane: src=[31:0], dst=[63:32], weight=[95:64]; [127:96] ignored.
REQ-013 An edge SHALL transfer when edge_valid && edge_ready; edge fields SHALL stay stable while edge_valid=1 && edge_ready=0.
REQ-014 A line written in cycle N SHALL make edge_valid=1 no earlier than cycle N+1 (empty FIFO: exactly N+1).
REQ-015 The FIFO head SHALL pop on the handshake of lane 3, or of the last edge; in both cases the lane index returns to 0.
REQ-016 A 32-bit emitted-edge counter SHALL advance per handshake; edge_last=1 when counter==num_edges-1.
REQ-017 Lanes after the last edge SHALL never be presented.
REQ-018 Lines arriving after the last edge SHALL be discarded.
REQ-019 drop SHALL be registered.
REQ-020 drop SHALL set when occupancy>=DROP_HI and clear when occupancy<=DROP_LO (hysteresis).
REQ-021 drop SHALL be 0 outside RUN.
REQ-022 A write and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 A write with the FIFO full and no same-cycle pop SHALL discard the line and set overflow_err until reset.
REQ-024 On entering IDLE, the FIFO SHALL be flushed and the counters cleared.

Reset
REQ-025 Reset SHALL set: state=IDLE, FIFO empty, lane index 0, edge counter 0.
REQ-026 Reset SHALL set all outputs to 0: drop, edge_valid, edge_last, done, overflow_err, edge fields.
REQ-027 Reset asserted mid-transfer SHALL abort it, with no done pulse.

Structure
REQ-028 The edge_t struct (src, dst, weight, pad), EDGES_PER_LINE=4 and EDGE_BITS=128 SHALL live in shared package sssp_pkg.
REQ-029 Line buffering SHALL be a sub-module line_fifo (synchronous, 512-bit wide, parameterised depth, count output, full/empty flags).

Verification
REQ-030 num_edges=8, two lines, edge_ready=1 -> 8 edges in lane order, edge_last on the 8th, done 1 cycle after.
REQ-031 num_edges=5, two lines -> 5 edges; lanes 1..3 of line 2 never emitted; done pulse.
REQ-032 num_edges=0, start -> done pulse 1 cycle later, no edge_valid.
REQ-033 edge_ready=0, 6 lines pushed -> drop=1 once occupancy is 6; edge_ready=1 -> drop=0 once occupancy is 4; no overflow_err.
REQ-034 FIFO filled to 8, then line_valid held -> overflow_err=1 and stays 1.
REQ-035 Reset pulsed mid-transfer -> all outputs 0; the next start completes normally.

Source files
------------

// File: rtl/sssp_pkg.sv
// sssp_pkg: shared edge/line types and lane extraction for the SSSP datapath
package sssp_pkg;
    localparam int EDGES_PER_LINE = 4;
    localparam int EDGE_BITS = 128;
    localparam int LINE_BITS = EDGES_PER_LINE * EDGE_BITS;

    typedef struct packed {
        logic [31:0] pad;
        logic [31:0] weight;
        logic [31:0] dst;
        logic [31:0] src;
    } edge_t;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    function automatic edge_t lane_of(input logic [LINE_BITS-1:0] line, input logic [1:0] k);
        return edge_t'(line[k*EDGE_BITS +: EDGE_BITS]);
    endfunction
endpackage

// File: rtl/line_fifo.sv
// line_fifo: synchronous cache-line FIFO with occupancy count and flush
module line_fifo
    import sssp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [LINE_BITS-1:0]   wr_data_i,
    input  logic                   rd_en_i,
    output logic [LINE_BITS-1:0]   rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [LINE_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic do_wr, do_rd;

    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign do_wr = wr_en_i && (!full_o || rd_en_i);
    assign do_rd = rd_en_i && !empty_o;
    assign full_o = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // storage array, no reset needed since reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/edge_line_unpacker.sv
// edge_line_unpacker: buffers 512-bit edge lines and emits their four edges one at a time
module edge_line_unpacker
    import sssp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_HI = FIFO_DEPTH - 2,
    parameter int DROP_LO = FIFO_DEPTH - 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          num_edges,
    input  logic [LINE_BITS-1:0] line_in,
    input  logic                 line_valid,
    output logic                 drop,
    output logic [31:0]          edge_src,
    output logic [31:0]          edge_dst,
    output logic [31:0]          edge_weight,
    output logic                 edge_valid,
    input  logic                 edge_ready,
    output logic                 edge_last,
    output logic                 done,
    output logic                 overflow_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HI = CW'(DROP_HI);
    localparam logic [CW-1:0] LO = CW'(DROP_LO);

    state_t state_q, state_d;
    logic [31:0] num_q, cnt_q, cnt_d;
    logic [1:0] lane_q, lane_d;
    logic drop_q, drop_d, ovf_q;
    logic [LINE_BITS-1:0] head;
    logic [CW-1:0] count;
    logic full, empty, run, is_last, hs, pop, wr;

    line_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (state_q == FINISH),
        .wr_en_i   (wr),
        .wr_data_i (line_in),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign run = state_q == RUN;
    assign wr = run && line_valid;
    assign is_last = cnt_q == num_q - 32'd1;
    assign edge_valid = run && !empty;
    assign hs = edge_valid && edge_ready;
    assign pop = hs && (lane_q == 2'd3 || is_last);
    assign edge_last = edge_valid && is_last;
    assign edge_src = edge_valid ? lane_of(head, lane_q).src : '0;
    assign edge_dst = edge_valid ? lane_of(head, lane_q).dst : '0;
    assign edge_weight = edge_valid ? lane_of(head, lane_q).weight : '0;
    assign done = state_q == FINISH;
    assign drop = drop_q;
    assign overflow_err = ovf_q;

    // next-state: transfer sequencing, edge/lane counters and drop hysteresis
    always_comb begin
        state_d = (state_q == IDLE && start) ? ((num_edges == '0) ? FINISH : RUN) :
                  (run && hs && is_last) ? FINISH :
                  (state_q == FINISH) ? IDLE : state_q;
        cnt_d = (state_q == FINISH) ? '0 : hs ? cnt_q + 32'd1 : cnt_q;
        lane_d = (state_q == FINISH || pop) ? 2'd0 : hs ? lane_q + 2'd1 : lane_q;
        drop_d = (state_d != RUN) ? 1'b0 : (count >= HI) ? 1'b1 : (count <= LO) ? 1'b0 : drop_q;
    end

    // control registers; overflow is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_q <= '0;
            cnt_q <= '0;
            lane_q <= '0;
            drop_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q <= (state_q == IDLE && start) ? num_edges : num_q;
            cnt_q <= cnt_d;
            lane_q <= lane_d;
            drop_q <= drop_d;
            ovf_q <= ovf_q | (wr && full && !pop);
        end
    end
endmodule

// File: tb/tb_edge_line_unpacker.sv
// tb_edge_line_unpacker: directed scoreboard bench for edge_line_unpacker
module tb_edge_line_unpacker;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, line_valid = 1'b0, edge_ready = 1'b0;
    logic [31:0] num_edges = '0;
    logic [511:0] line_in = '0;
    logic drop, edge_valid, edge_last, done, overflow_err;
    logic [31:0] edge_src, edge_dst, edge_weight;

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] w;
        logic l;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0, hs_count = 0, last_hs_cyc = -10, issued = 0, n_cur = 0;

    edge_line_unpacker dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_edges    (num_edges),
        .line_in      (line_in),
        .line_valid   (line_valid),
        .drop         (drop),
        .edge_src     (edge_src),
        .edge_dst     (edge_dst),
        .edge_weight  (edge_weight),
        .edge_valid   (edge_valid),
        .edge_ready   (edge_ready),
        .edge_last    (edge_last),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] fs(input int id, input int k);
        return 32'(id * 16 + k);
    endfunction
    function automatic logic [31:0] fd(input int id, input int k);
        return 32'h1000_0000 + fs(id, k);
    endfunction
    function automatic logic [31:0] fw(input int id, input int k);
        return 32'h2000_0000 + fs(id, k);
    endfunction

    function automatic logic [511:0] mk_line(input int id);
        logic [511:0] l;
        for (int k = 0; k < 4; k++) l[k*128 +: 128] = {32'hBAD0_0000 | 32'(k), fw(id, k), fd(id, k), fs(id, k)};
        return l;
    endfunction

    // one line in one cycle; expectations only for lanes inside the transfer
    task automatic send_line(input int id);
        line_in = mk_line(id);
        line_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (issued < n_cur) begin
                exp_q.push_back('{fs(id, k), fd(id, k), fw(id, k), issued == n_cur - 1});
                issued++;
            end
        end
        @(posedge clk); #1;
        line_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        num_edges = 32'(n);
        n_cur = n;
        issued = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (!done && t < 300);
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_done_lat"}, 32'(cyc), 32'(last_hs_cyc + 1));
        chk({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_idle_novalid"}, 32'(edge_valid), 32'd0);
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (hs_count < n && t < 300);
        chk("hs_reached", 32'(hs_count), 32'(n));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(edge_valid), 32'd0);
        chk({nm, "_last"}, 32'(edge_last), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_drop"}, 32'(drop), 32'd0);
        chk({nm, "_ovf"}, 32'(overflow_err), 32'd0);
        chk({nm, "_src"}, edge_src, 32'd0);
        chk({nm, "_dst"}, edge_dst, 32'd0);
        chk({nm, "_weight"}, edge_weight, 32'd0);
    endtask

    // monitor: every presented edge must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && edge_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_edge: got src %h with nothing expected", edge_src);
            end else begin
                chk("edge_src", edge_src, exp_q[0].s);
                chk("edge_dst", edge_dst, exp_q[0].d);
                chk("edge_weight", edge_weight, exp_q[0].w);
                chk("edge_last", 32'(edge_last), 32'(exp_q[0].l));
                if (edge_ready) begin
                    void'(exp_q.pop_front());
                    hs_count++;
                    if (edge_last) last_hs_cyc = cyc;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        // two full lines, consumer always ready
        edge_ready = 1'b1;
        do_start(8);
        send_line(0);
        send_line(1);
        wait_done("t8");
        // transfer ends in lane 0 of the second line
        do_start(5);
        send_line(2);
        send_line(3);
        wait_done("t5");
        // empty transfer
        do_start(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_novalid", 32'(edge_valid), 32'd0);
        @(posedge clk); #1;
        chk("zero_done_pulse", 32'(done), 32'd0);
        // drop hysteresis with a stalled consumer
        edge_ready = 1'b0;
        do_start(24);
        for (int i = 0; i < 5; i++) send_line(10 + i);
        repeat (2) @(posedge clk);
        #1;
        chk("drop_occ5", 32'(drop), 32'd0);
        send_line(15);
        @(posedge clk); #1;
        chk("drop_occ6", 32'(drop), 32'd1);
        hs_count = 0;
        edge_ready = 1'b1;
        wait_hs(4);
        @(negedge clk); #1;
        chk("drop_occ5_hold", 32'(drop), 32'd1);
        wait_hs(8);
        @(negedge clk); #1;
        chk("drop_occ4_reg", 32'(drop), 32'd1);
        @(negedge clk); #1;
        chk("drop_occ4_clear", 32'(drop), 32'd0);
        wait_done("t24");
        chk("t24_ovf", 32'(overflow_err), 32'd0);
        // overflow: fill the buffer, keep writing
        edge_ready = 1'b0;
        do_start(100);
        for (int i = 0; i < 8; i++) send_line(30 + i);
        chk("full_no_ovf", 32'(overflow_err), 32'd0);
        chk("full_drop", 32'(drop), 32'd1);
        send_line(38);
        chk("ovf_set", 32'(overflow_err), 32'd1);
        send_line(39);
        send_line(40);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        // reset mid-transfer, then a clean transfer
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        chk("midreset_nodone", 32'(done), 32'd0);
        reset = 1'b0;
        edge_ready = 1'b1;
        do_start(4);
        send_line(50);
        wait_done("t_after_reset");
        chk("after_reset_ovf", 32'(overflow_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1);
    end
endmodule
